// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM request bundle plus shared memory port for mem_port_arbiter
//
// Ports (slave = arbiter side, master = pipeline + memory side):
//   fetch : if_req, if_addr -> if_done, if_rdata, if_stall
//   data  : d_req, d_we, d_addr, d_wdata, d_be -> d_done, d_rdata, d_stall
//   memory: m_en, m_we, m_addr, m_wdata, m_be -> m_rdata
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_rdata,
        output if_done, if_rdata, if_stall,
        output d_done, d_rdata, d_stall,
        output m_en, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_rdata,
        input  if_done, if_rdata, if_stall,
        input  d_done, d_rdata, d_stall,
        input  m_en, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter/sequencer for the IF and MEM stages
//
// Serves one access at a time to a fixed-latency synchronous memory. Data has
// priority; after STARVE_MAX consecutive data grants with fetch waiting, fetch
// wins the next tie.
//
// Ports:
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave: fetch request/response, data
//          request/response, stall outputs and the memory port
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    mem_port_arbiter_if.slave     bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] wait_cnt;
    // Owner of the access in flight, and whether it is a store. The store flag
    // is kept separately because m_we drops after ISSUE.
    logic          owner_data;
    logic          owner_store;

    logic any_req;
    logic grant_data;

    assign any_req    = bus.if_req | bus.d_req;
    // Data wins unless fetch is also waiting and has been passed over
    // STARVE_MAX times in a row.
    assign grant_data = bus.d_req & (~bus.if_req | (starve_cnt != STARVE_LIM));

    assign bus.if_stall = bus.if_req & ~bus.if_done;
    assign bus.d_stall  = bus.d_req & ~bus.d_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            wait_cnt     <= '0;
            owner_data   <= 1'b0;
            owner_store  <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.d_done   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            bus.m_en     <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.m_be     <= '0;
        end else begin
            // Strobes are single-cycle; only the IDLE grant and the last
            // WAIT edge raise them for the following cycle.
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ISSUE;
                        bus.m_en   <= 1'b1;
                        owner_data <= grant_data;
                        if (grant_data) begin
                            owner_store <= bus.d_we;
                            bus.m_we    <= bus.d_we;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            bus.m_be    <= bus.d_be;
                            if (!bus.if_req) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != STARVE_LIM) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            owner_store <= 1'b0;
                            bus.m_we    <= 1'b0;
                            bus.m_addr  <= bus.if_addr;
                            bus.m_wdata <= '0;
                            bus.m_be    <= 4'hF;
                            starve_cnt  <= '0;
                        end
                    end
                end

                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_LOAD;
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        // m_rdata is valid exactly on this closing edge.
                        state <= RESP;
                        if (owner_data) begin
                            bus.d_done <= 1'b1;
                            if (!owner_store) begin
                                bus.d_rdata <= bus.m_rdata;
                            end
                        end else begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.m_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                RESP: begin
                    // The finished requester's req is still stale here, so
                    // arbitration waits for IDLE.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_en_only_in_issue: assert property (@(posedge clk) disable iff (!rstn)
        bus.m_en |-> (state == ISSUE));

    a_done_exclusive: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.if_done && bus.d_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if bus0();
    mem_port_arbiter_if bus1();

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0050_0083;
    endfunction

    // Memory models: data is valid only in the single cycle MEM_LAT after m_en.
    logic [31:0] m0_s0 = POISON;
    logic [31:0] m0_s1 = POISON;
    logic [31:0] m1_s0 = POISON;
    always @(posedge clk) begin
        m0_s0 <= bus0.m_en ? mem_word(bus0.m_addr) : POISON;
        m0_s1 <= m0_s0;
        m1_s0 <= bus1.m_en ? mem_word(bus1.m_addr) : POISON;
    end
    assign bus0.m_rdata = m0_s1;
    assign bus1.m_rdata = m1_s0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } issue_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } done_t;

    issue_t iss_q[$];
    done_t  if_q[$];
    done_t  d_q[$];
    issue_t mon_i;
    done_t  mon_d;

    always @(negedge clk) begin
        if (bus0.m_en) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                mon_i = iss_q.pop_front();
                check("issue_cycle", cyc, mon_i.cyc);
                check("issue_addr", bus0.m_addr, mon_i.addr);
                check("issue_we", bus0.m_we, mon_i.we);
                check("issue_wdata", bus0.m_wdata, mon_i.wdata);
                check("issue_be", bus0.m_be, mon_i.be);
            end
        end
        if (bus0.if_done) begin
            if (if_q.size() == 0) begin
                check("unexpected_if_done", 32'd1, 32'd0);
            end else begin
                mon_d = if_q.pop_front();
                check("if_done_cycle", cyc, mon_d.cyc);
                check("if_rdata", bus0.if_rdata, mon_d.rdata);
            end
        end
        if (bus0.d_done) begin
            if (d_q.size() == 0) begin
                check("unexpected_d_done", 32'd1, 32'd0);
            end else begin
                mon_d = d_q.pop_front();
                check("d_done_cycle", cyc, mon_d.cyc);
                check("d_rdata", bus0.d_rdata, mon_d.rdata);
            end
        end
    end

    task automatic hold_until_done(input bit is_data);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (is_data ? bus0.d_done : bus0.if_done) begin
                seen = 1'b1;
                check(is_data ? "d_stall_at_done" : "if_stall_at_done",
                      is_data ? bus0.d_stall : bus0.if_stall, 32'd0);
            end else begin
                check(is_data ? "d_stall_pending" : "if_stall_pending",
                      is_data ? bus0.d_stall : bus0.if_stall, 32'd1);
            end
        end
        if (!seen) check(is_data ? "d_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (is_data) bus0.d_req = 1'b0;
        else         bus0.if_req = 1'b0;
    endtask

    task automatic run_fetch(input logic [31:0] addr);
        bus0.if_addr = addr;
        bus0.if_req  = 1'b1;
        hold_until_done(1'b0);
    endtask

    task automatic run_data(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        bus0.d_we    = we;
        bus0.d_addr  = addr;
        bus0.d_wdata = wdata;
        bus0.d_be    = be;
        bus0.d_req   = 1'b1;
        hold_until_done(1'b1);
    endtask

    logic [31:0] last_d = '0;
    int c0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = 0; bus0.d_wdata = 0; bus0.d_be = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_be = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_en", bus0.m_en, 0);
        check("rst_m_addr", bus0.m_addr, 0);
        check("rst_m_be", bus0.m_be, 0);
        check("rst_if_rdata", bus0.if_rdata, 0);
        check("rst_d_rdata", bus0.d_rdata, 0);
        check("rst_done", {bus0.if_done, bus0.d_done}, 0);
        rstn = 1'b1;

        // Single fetch
        @(posedge clk); #1; c0 = cyc;
        iss_q.push_back('{cyc: c0+1, addr: 32'h10, we: 1'b0, wdata: 32'h0, be: 4'hF});
        if_q.push_back('{cyc: c0+4, rdata: 32'h0050_0093});
        run_fetch(32'h10);

        // Load, then store leaves d_rdata untouched
        @(posedge clk); #1; c0 = cyc;
        iss_q.push_back('{cyc: c0+1, addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'hF});
        d_q.push_back('{cyc: c0+4, rdata: mem_word(32'h200)});
        run_data(1'b0, 32'h200, 32'h0, 4'hF);
        last_d = mem_word(32'h200);

        @(posedge clk); #1; c0 = cyc;
        iss_q.push_back('{cyc: c0+1, addr: 32'h100, we: 1'b1, wdata: 32'hDEAD_BEEF, be: 4'b0011});
        d_q.push_back('{cyc: c0+4, rdata: last_d});
        run_data(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        repeat (3) @(negedge clk);
        check("d_rdata_held_after_store", bus0.d_rdata, last_d);

        // Collision: data first, fetch right after
        @(posedge clk); #1; c0 = cyc;
        iss_q.push_back('{cyc: c0+1, addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'hF});
        iss_q.push_back('{cyc: c0+6, addr: 32'h14, we: 1'b0, wdata: 32'h0, be: 4'hF});
        d_q.push_back('{cyc: c0+4, rdata: mem_word(32'h200)});
        if_q.push_back('{cyc: c0+9, rdata: mem_word(32'h14)});
        fork
            run_data(1'b0, 32'h200, 32'h0, 4'hF);
            run_fetch(32'h14);
        join
        check("starve_after_fetch", 32'(dut.starve_cnt), 0);

        // Starvation: both held for ten grants, pattern DDDDF DDDDF
        @(posedge clk); #1; c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                iss_q.push_back('{cyc: c0+1+5*k, addr: 32'h40, we: 1'b0, wdata: 32'h0, be: 4'hF});
                if_q.push_back('{cyc: c0+4+5*k, rdata: mem_word(32'h40)});
            end else begin
                iss_q.push_back('{cyc: c0+1+5*k, addr: 32'h300, we: 1'b0, wdata: 32'h0, be: 4'hF});
                d_q.push_back('{cyc: c0+4+5*k, rdata: mem_word(32'h300)});
            end
        end
        bus0.if_addr = 32'h40; bus0.if_req = 1'b1;
        bus0.d_we = 1'b0; bus0.d_addr = 32'h300; bus0.d_wdata = 32'h0; bus0.d_be = 4'hF;
        bus0.d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            while (cyc < c0+1+5*k) @(negedge clk);
            check("starve_cnt", 32'(dut.starve_cnt), (k % 5 == 4) ? 32'd0 : 32'(k % 5 + 1));
        end
        while (cyc < c0+50) begin @(posedge clk); #1; end
        bus0.if_req = 1'b0;
        bus0.d_req  = 1'b0;
        last_d = mem_word(32'h300);

        // Reset during the first WAIT cycle of a load
        @(posedge clk); #1; c0 = cyc;
        iss_q.push_back('{cyc: c0+1, addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'hF});
        fork
            run_data(1'b0, 32'h200, 32'h0, 4'hF);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                rstn = 1'b0;
                #1;
                check("mid_rst_m_en", bus0.m_en, 0);
                check("mid_rst_m_addr", bus0.m_addr, 0);
                check("mid_rst_m_wdata", bus0.m_wdata, 0);
                check("mid_rst_m_be", bus0.m_be, 0);
                check("mid_rst_d_rdata", bus0.d_rdata, 0);
                check("mid_rst_if_rdata", bus0.if_rdata, 0);
                check("mid_rst_done", {bus0.if_done, bus0.d_done}, 0);
                check("mid_rst_starve", 32'(dut.starve_cnt), 0);
                iss_q.push_back('{cyc: c0+3, addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'hF});
                d_q.push_back('{cyc: c0+6, rdata: mem_word(32'h200)});
                #1;
                rstn = 1'b1;
            end
        join

        // MEM_LAT=1 instance: single fetch
        @(posedge clk); #1; c0 = cyc;
        bus1.if_addr = 32'h20;
        bus1.if_req  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("l1_m_en", bus1.m_en, (j == 1) ? 32'd1 : 32'd0);
            if (j == 1) check("l1_m_addr", bus1.m_addr, 32'h20);
            check("l1_if_done", bus1.if_done, (j == 3) ? 32'd1 : 32'd0);
            if (j == 3) check("l1_if_rdata", bus1.if_rdata, mem_word(32'h20));
            check("l1_if_stall", bus1.if_stall, (j < 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        bus1.if_req = 1'b0;
        @(negedge clk);
        check("l1_idle_m_en", bus1.m_en, 0);

        repeat (4) @(negedge clk);
        check("iss_q_drained", iss_q.size(), 0);
        check("if_q_drained", if_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single shared memory port in the pipelined RISC-V core. It serves the IF stage (instruction fetch) and the MEM stage (load/store), issues one access at a time to a fixed-latency synchronous memory, and returns a one-cycle completion pulse with captured read data. It also produces the per-stage stall signals that freeze the pipeline while an access is pending. The data port has priority; a starvation counter guarantees that fetch makes forward progress.

## Interface
- MEM_LAT, 2, cycles from the m_en cycle to m_rdata valid (≥1)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched word; valid while if_done=1, held afterwards
- if_stall  out  1  if_req & ~if_done (combinational)
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_done  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data; valid while d_done=1, held afterwards
- d_stall  out  1  d_req & ~d_done (combinational)
- m_en  out  1  memory access strobe, high for exactly one cycle per access
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_be  out  4  memory byte enables
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after m_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, select the owner, latch the address, we, wdata and be into the m_* registers, and go to ISSUE. Otherwise stay in IDLE.
- Selection rule: if only one request is pending, that requester wins. If both are pending, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- For a fetch grant the registers load m_we=0, m_be=4'hF and m_wdata=0.
- ISSUE: m_en=1 for one cycle, then go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles, tracked by a down-counter. On the closing edge of the final WAIT cycle:
  - for a fetch or a load, capture m_rdata into the owner's rdata register;
  - for a store, leave d_rdata unchanged.
  - Then go to RESP.
- RESP: assert the owner's done for one cycle, then always go to IDLE. There is no re-arbitration in RESP, because the finished requester's req is still stale during that cycle.
- starve_cnt (saturating, width clog2(STARVE_MAX+1)) updates at each grant:
  - data grant with if_req=1: increment;
  - data grant with if_req=0: clear to 0;
  - fetch grant: clear to 0.
- Dropped request: if a requester lowers req mid-access, the access still completes and done still pulses. The requester ignores it.
- Outside ISSUE, m_en=0 and m_we=0. m_addr, m_wdata and m_be hold their last values.

## Timing
- Reset (asynchronous, rstn=0): the FSM goes to IDLE and starve_cnt, the counter, if_done, d_done, if_rdata, d_rdata, m_en, m_we, m_addr, m_wdata and m_be all go to 0.
  - A reset during ISSUE, WAIT or RESP abandons the access: no done is issued, and a store whose m_en already fired is not undone.
- Cycle sequence for a request first seen in IDLE at cycle t:
  - ISSUE at t+1;
  - WAIT at t+2 … t+1+MEM_LAT;
  - m_rdata sampled at the end of cycle t+1+MEM_LAT;
  - done at t+2+MEM_LAT;
  - IDLE at t+3+MEM_LAT.
- Request-to-done latency is MEM_LAT+2 cycles. Minimum spacing between consecutive m_en pulses is MEM_LAT+3 cycles.
- A request arriving while the FSM is busy waits in IDLE arbitration, at the earliest at t+3+MEM_LAT. The losing requester's stall stays high throughout.
- Simultaneous if_req and d_req rises: resolved by the selection rule in a single IDLE cycle. No cycle is lost to ties.

## Test plan
- MEM_LAT=2; if_req=1 with if_addr=0x10 in cycle 0; the memory model returns 0x00500093. Required: m_en=1 with m_addr=0x10 and m_we=0 in cycle 1; if_done=1 with if_rdata=0x00500093 in cycle 4; if_stall=1 in cycles 0–3.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011. Required: m_en=m_we=1, m_be=0011, m_wdata=0xDEADBEEF in the ISSUE cycle; d_done 4 cycles after the request; d_rdata unchanged.
- Collision: if_req and d_req both rise in cycle 0 (load at 0x200). Required: data issues in cycle 1 and d_done in cycle 4; the fetch issues in cycle 6 and if_done in cycle 9; if_stall high in cycles 0–8.
- Starvation, STARVE_MAX=4: d_req and if_req held high continuously. Required: 4 data grants, then 1 fetch grant, then the pattern repeats; starve_cnt reads 0 after the fetch grant.
- Reset mid-WAIT: rstn pulsed low during a load's first WAIT cycle. Required: all outputs read 0 immediately; no d_done occurs; after rstn rises with d_req held, a fresh access issues normally.
- MEM_LAT=1: a single fetch. Required: done 3 cycles after the request, and m_rdata is sampled the cycle after m_en.
